// File: rtl/counter_event_capture.sv
// Edge-timestamp capture: samples count_in on selected event_in edges
// into a small FWFT FIFO, with sticky overflow and saturating drop count.
module counter_event_capture #(
   parameter int WIDTH  = 4,
   parameter int ADDR_W = 2,
   parameter int DROP_W = 8
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              event_in,
   input  logic [1:0]        edge_sel,
   input  logic              flush,
   output logic [WIDTH-1:0]  cap_data,
   output logic              cap_valid,
   input  logic              cap_ready,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   input  logic              ovf_clr,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W-1:0] r_rptr;
   logic [ADDR_W:0]   r_level;
   logic [WIDTH-1:0]  r_data;
   logic              r_ev_q;
   logic              r_armed;
   logic              r_ovf;
   logic [DROP_W-1:0] r_drop;

   logic              w_rise;
   logic              w_fall;
   logic              w_sel;
   logic              w_hit;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic [ADDR_W-1:0] w_rptr_nxt;

   assign w_rise     = event_in & ~r_ev_q;
   assign w_fall     = ~event_in & r_ev_q;
   assign w_full     = (r_level == FULL_LVL);
   assign w_pop      = (r_level != '0) & cap_ready & ~flush;
   assign w_push     = w_hit & ~flush & (~w_full | w_pop);
   assign w_drop     = w_hit & ~flush & w_full & ~w_pop;
   assign w_rptr_nxt = r_rptr + ADDR_W'(1);

   // Edge select; nothing is detected until the history register is armed
   always_comb begin
      w_sel = 1'b0;
      case (edge_sel)
         2'b00:   w_sel = w_rise;
         2'b01:   w_sel = w_fall;
         2'b10:   w_sel = w_rise | w_fall;
         default: w_sel = 1'b0;
      endcase
      w_hit = r_armed & w_sel;
   end

   // Edge history and arming after reset release
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_ev_q  <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_ev_q  <= event_in;
         r_armed <= 1'b1;
      end
   end

   // Sample storage; contents are don't-care while level says empty
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= count_in;
   end

   // Pointers and explicit occupancy; flush overrides push and pop
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + ADDR_W'(1);
         if (w_pop)  r_rptr <= w_rptr_nxt;
         if (w_push && !w_pop)
            r_level <= r_level + (ADDR_W+1)'(1);
         else if (w_pop && !w_push)
            r_level <= r_level - (ADDR_W+1)'(1);
      end
   end

   // Registered head word; holds the last value once the FIFO drains
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_data <= '0;
      end else if (w_pop) begin
         if (r_level > (ADDR_W+1)'(1))
            r_data <= r_mem[w_rptr_nxt];
         else if (w_push)
            r_data <= count_in;
      end else if (w_push && r_level == '0) begin
         r_data <= count_in;
      end
   end

   // Sticky overflow and saturating drop count; a drop beats a clear
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_ovf  <= 1'b0;
         r_drop <= '0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
         if (ovf_clr)
            r_drop <= DROP_W'(1);
         else if (!(&r_drop))
            r_drop <= r_drop + DROP_W'(1);
      end else if (ovf_clr) begin
         r_ovf  <= 1'b0;
         r_drop <= '0;
      end
   end

   assign cap_data  = r_data;
   assign cap_valid = (r_level != '0);
   assign level     = r_level;
   assign overflow  = r_ovf;
   assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_counter_event_capture.sv
// Scoreboard bench for counter_event_capture: expected samples are queued
// at stimulus time and checked by a monitor whenever a pop is presented.
module tb_counter_event_capture;

   logic       clk = 1'b0;
   logic       clr_n;
   logic [3:0] count_in;
   logic       event_in;
   logic [1:0] edge_sel;
   logic       flush;
   logic [3:0] cap_data;
   logic       cap_valid;
   logic       cap_ready;
   logic [2:0] level;
   logic       overflow;
   logic       ovf_clr;
   logic [7:0] drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] q[$];

   counter_event_capture #(.WIDTH(4), .ADDR_W(2), .DROP_W(8)) dut (
      .clk(clk), .clr_n(clr_n), .count_in(count_in),
      .event_in(event_in), .edge_sel(edge_sel), .flush(flush),
      .cap_data(cap_data), .cap_valid(cap_valid),
      .cap_ready(cap_ready), .level(level), .overflow(overflow),
      .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tog(input logic [3:0] c, input bit exp);
      event_in = ~event_in;
      count_in = c;
      if (exp) q.push_back(c);
      tick();
   endtask

   task automatic drain(input int n);
      cap_ready = 1'b1;
      repeat (n) tick();
      cap_ready = 1'b0;
   endtask

   // Monitor: a pop happens at the coming posedge when valid & ready
   always @(negedge clk) begin
      if (clr_n && cap_valid && cap_ready && !flush) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got %0d expected none", cap_data);
         end else begin
            chk("pop_data", cap_data, q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      clr_n = 0; count_in = 0; event_in = 1; edge_sel = 2'b00;
      flush = 0; cap_ready = 0; ovf_clr = 0;
      tick(); tick();
      chk("rst_level", level, 0);
      chk("rst_valid", cap_valid, 0);
      chk("rst_data", cap_data, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_drop", drop_cnt, 0);

      // 1: high event at release is not an edge
      clr_n = 1;
      tick(); tick(); tick();
      chk("t1_noarm_edge", level, 0);
      tog(4'd3, 0);
      tog(4'd5, 1);
      chk("t1_valid", cap_valid, 1);
      chk("t1_data", cap_data, 5);
      chk("t1_level", level, 1);
      drain(1);
      chk("t1_drained", level, 0);
      chk("t1_hold", cap_data, 5);

      // 2: both edges, fill then overflow, then drain in order
      edge_sel = 2'b10;
      for (int i = 0; i < 16; i++) begin
         tog(4'(i), i < 4);
         if (i >= 4) chk("t2_drop", drop_cnt, i - 3);
      end
      chk("t2_level", level, 4);
      chk("t2_ovf", overflow, 1);
      chk("t2_head", cap_data, 0);
      drain(4);
      chk("t2_empty", level, 0);

      // 3: full with concurrent pop and hit, pointers wrap
      for (int i = 7; i <= 10; i++) tog(4'(i), 1);
      chk("t3_full", level, 4);
      cap_ready = 1;
      tog(4'd11, 1);
      chk("t3_level", level, 4);
      chk("t3_nodrop", drop_cnt, 12);
      chk("t3_head", cap_data, 8);
      drain(4);
      chk("t3_empty", level, 0);

      // 4: falling only, then disabled
      edge_sel = 2'b01;
      for (int i = 1; i <= 6; i++) tog(4'(i), event_in == 1'b1);
      chk("t4_fall_level", level, 3);
      drain(3);
      chk("t4_empty", level, 0);
      edge_sel = 2'b11;
      for (int i = 0; i < 20; i++) tog(4'(i), 0);
      chk("t4_disabled", level, 0);
      chk("t4_valid", cap_valid, 0);

      // 5: flush beats hit and pop; clear vs concurrent drop
      edge_sel = 2'b10;
      for (int i = 1; i <= 3; i++) tog(4'(i), 1);
      chk("t5_level3", level, 3);
      flush = 1; cap_ready = 1;
      q.delete();
      tog(4'd9, 0);
      flush = 0; cap_ready = 0;
      chk("t5_flush_level", level, 0);
      chk("t5_flush_valid", cap_valid, 0);
      chk("t5_flush_drop", drop_cnt, 12);
      chk("t5_flush_ovf", overflow, 1);
      for (int i = 4; i <= 7; i++) tog(4'(i), 1);
      ovf_clr = 1;
      tog(4'd8, 0);
      ovf_clr = 0;
      chk("t5_clr_drop", drop_cnt, 1);
      chk("t5_clr_ovf", overflow, 1);
      ovf_clr = 1;
      tick();
      ovf_clr = 0;
      chk("t5_clr_only_drop", drop_cnt, 0);
      chk("t5_clr_only_ovf", overflow, 0);
      chk("t5_head", cap_data, 4);

      // 6: saturation, then asynchronous reset mid-stream
      for (int i = 0; i < 300; i++) tog(4'(i), 0);
      chk("t6_sat", drop_cnt, 255);
      chk("t6_ovf", overflow, 1);
      chk("t6_level", level, 4);
      #2;
      clr_n = 0;
      q.delete();
      #1;
      chk("t6_rst_level", level, 0);
      chk("t6_rst_valid", cap_valid, 0);
      chk("t6_rst_data", cap_data, 0);
      chk("t6_rst_ovf", overflow, 0);
      chk("t6_rst_drop", drop_cnt, 0);
      tick();
      clr_n = 1;
      tick(); tick();
      chk("end_queue", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
